// File: rtl/adder_dsp_arbiter.sv
// adder_dsp_arbiter: round-robin sharing of one combinational adder_dsp among NUM_REQ requesters
module adder_dsp_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_sub,
  output logic [NUM_REQ-1:0]       resp_valid,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]         resp_data,
  output logic [WIDTH-1:0]         dsp_in1,
  output logic [WIDTH-1:0]         dsp_in2,
  output logic                     dsp_is_sub,
  input  logic [WIDTH-1:0]         dsp_out
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic [IW-1:0] rr, gid, grant;
  logic any;
  int idx;
  // walk downward so the requester closest to rr (upward, with wrap) wins
  always_comb begin
    grant = '0;
    any = 1'b0;
    idx = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx]) begin
        grant = IW'(idx);
        any = 1'b1;
      end
    end
  end
  assign req_ready = (state == IDLE && any) ? NUM_REQ'(1) << grant : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      rr         <= '0;
      gid        <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      dsp_in1    <= '0;
      dsp_in2    <= '0;
      dsp_is_sub <= 1'b0;
    end else
      case (state)
        IDLE: if (any) begin
          dsp_in1    <= req_a[grant*WIDTH +: WIDTH];
          dsp_in2    <= req_b[grant*WIDTH +: WIDTH];
          dsp_is_sub <= req_sub[grant];
          gid        <= grant;
          rr         <= (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
          state      <= EXEC;
        end
        EXEC: begin
          resp_data  <= dsp_out;
          resp_valid <= NUM_REQ'(1) << gid;
          state      <= RESP;
        end
        RESP: if (resp_ready[gid]) begin
          resp_valid <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_adder_dsp_arbiter.sv
// tb_adder_dsp_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_adder_dsp_arbiter;
  localparam int NR = 4;
  localparam int W  = 32;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [NR-1:0] req_valid = '0, req_sub = '0, resp_ready = '1;
  logic [NR-1:0] req_ready, resp_valid;
  logic [NR*W-1:0] req_a = '0, req_b = '0;
  logic [W-1:0] resp_data, dsp_in1, dsp_in2, dsp_out;
  logic dsp_is_sub;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;
  assign dsp_out = dsp_is_sub ? dsp_in1 - dsp_in2 : dsp_in1 + dsp_in2;

  adder_dsp_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .dsp_in1(dsp_in1),
    .dsp_in2(dsp_in2), .dsp_is_sub(dsp_is_sub), .dsp_out(dsp_out)
  );

  function automatic logic [W-1:0] ref_op(logic [W-1:0] a, logic [W-1:0] b, logic s);
    return s ? a - b : a + b;
  endfunction

  task automatic set_req(int i, logic [W-1:0] a, logic [W-1:0] b, logic s);
    req_valid[i] = 1'b1;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_sub[i] = s;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0;
    resp_ready = '1;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, dsp_is_sub} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: req_ready=%b resp_valid=%b is_sub=%b, want all 0", req_ready, resp_valid, dsp_is_sub);
    end
    checks++;
    if (resp_data !== '0 || dsp_in1 !== '0 || dsp_in2 !== '0) begin
      errors++;
      $display("FAIL reset_data: resp_data=%h in1=%h in2=%h, want 0", resp_data, dsp_in1, dsp_in2);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    @(negedge clk);
    set_req(0, 32'd5, 32'd3, 1'b0);
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL basic_ready: got %b want 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    req_a[0 +: W] = 32'hDEAD_BEEF;
    req_b[0 +: W] = 32'h1234_5678;
    checks++;
    if (resp_valid !== '0 || dsp_in1 !== 32'd5 || dsp_in2 !== 32'd3) begin
      errors++;
      $display("FAIL basic_exec: resp_valid=%b in1=%h in2=%h want 0/5/3", resp_valid, dsp_in1, dsp_in2);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 4'b0001 || resp_data !== 32'd8) begin
      errors++;
      $display("FAIL basic_resp: valid=%b data=%h want 0001/00000008", resp_valid, resp_data);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== '0) begin errors++; $display("FAIL basic_done: resp_valid=%b want 0", resp_valid); end
  endtask

  task automatic test_carry();
    logic [W-1:0] ta [3];
    logic [W-1:0] tb [3];
    logic [W-1:0] te [3];
    logic ts [3];
    ta = '{32'h0000_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
    tb = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001};
    ts = '{1'b0, 1'b1, 1'b0};
    te = '{32'h0001_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      set_req(2, ta[k], tb[k], ts[k]);
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin errors++; $display("FAIL carry_ready[%0d]: got %b want 0100", k, req_ready); end
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      checks++;
      if (resp_valid !== 4'b0100 || resp_data !== te[k]) begin
        errors++;
        $display("FAIL carry_resp[%0d]: valid=%b data=%h want 0100/%h", k, resp_valid, resp_data, te[k]);
      end
    end
  endtask

  task automatic test_alternate();
    logic [NR-1:0] eg;
    logic [W-1:0] ed;
    @(negedge clk);
    set_req(0, 32'd100, 32'd1, 1'b0);
    set_req(1, 32'd50, 32'd20, 1'b1);
    #1;
    for (int k = 0; k < 4; k++) begin
      eg = NR'(1) << (k % 2);
      ed = (k % 2) ? 32'd30 : 32'd101;
      checks++;
      if (req_ready !== eg) begin errors++; $display("FAIL alt_grant[%0d]: got %b want %b", k, req_ready, eg); end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (resp_valid !== eg || resp_data !== ed) begin
        errors++;
        $display("FAIL alt_resp[%0d]: valid=%b data=%h want %b/%h", k, resp_valid, resp_data, eg, ed);
      end
      @(negedge clk);
      #1;
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    set_req(1, 32'h1234_5678, 32'h1111_1111, 1'b0);
    resp_ready = 4'b1101;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant: got %b want 0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    req_a[W +: W] = '0;
    set_req(0, 32'd7, 32'd9, 1'b1);
    #1;
    checks++;
    if (req_ready !== '0) begin errors++; $display("FAIL bp_exec_ready: got %b want 0000", req_ready); end
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (resp_valid !== 4'b0010 || resp_data !== 32'h2345_6789 || req_ready !== '0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%h ready=%b want 0010/23456789/0000", k, resp_valid, resp_data, req_ready);
      end
      @(negedge clk);
    end
    resp_ready = '1;
    @(negedge clk);
    #1;
    checks++;
    if (resp_valid !== '0 || req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL bp_release: valid=%b ready=%b want 0000/0001", resp_valid, req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 4'b0001 || resp_data !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL bp_next: valid=%b data=%h want 0001/fffffffe", resp_valid, resp_data);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    set_req(2, 32'd10, 32'd20, 1'b0);
    @(negedge clk);
    req_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (resp_valid !== '0 || req_ready !== '0 || resp_data !== '0 || dsp_in1 !== '0 || dsp_in2 !== '0) begin
      errors++;
      $display("FAIL arst_now: valid=%b ready=%b data=%h in1=%h in2=%h want all 0", resp_valid, req_ready, resp_data, dsp_in1, dsp_in2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== '0) begin errors++; $display("FAIL arst_stale[%0d]: valid=%b want 0000", k, resp_valid); end
    end
  endtask

  task automatic test_lone();
    @(negedge clk);
    set_req(3, 32'h8000_0000, 32'h8000_0001, 1'b0);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (req_ready !== 4'b1000) begin errors++; $display("FAIL lone_grant[%0d]: got %b want 1000", k, req_ready); end
      @(negedge clk);
      #1;
      checks++;
      if (req_ready !== '0) begin errors++; $display("FAIL lone_exec[%0d]: got %b want 0000", k, req_ready); end
      @(negedge clk);
      #1;
      checks++;
      if (resp_valid !== 4'b1000 || resp_data !== 32'h0000_0001) begin
        errors++;
        $display("FAIL lone_resp[%0d]: valid=%b data=%h want 1000/00000001", k, resp_valid, resp_data);
      end
      @(negedge clk);
      #1;
    end
    set_req(0, 32'd1, 32'd2, 1'b0);
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL lone_wrap: got %b want 0001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_random();
    int m_rr = 0, phase = 0, eid = 0, g;
    logic [W-1:0] edata = '0;
    logic [NR-1:0] er;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      req_valid = NR'($urandom);
      resp_ready = NR'($urandom);
      for (int i = 0; i < NR; i++) begin
        req_a[i*W +: W] = $urandom;
        req_b[i*W +: W] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        req_sub[i] = 1'($urandom);
      end
      #1;
      if (phase == 0) begin
        g = -1;
        for (int k = 0; k < NR; k++)
          if (g < 0 && req_valid[(m_rr + k) % NR]) g = (m_rr + k) % NR;
        er = (g < 0) ? '0 : NR'(1) << g;
        checks++;
        if (req_ready !== er || resp_valid !== '0) begin
          errors++;
          $display("FAIL rand_idle@%0d: ready=%b valid=%b want %b/0000", c, req_ready, resp_valid, er);
        end
        if (g >= 0) begin
          eid = g;
          edata = ref_op(req_a[g*W +: W], req_b[g*W +: W], req_sub[g]);
          m_rr = (g + 1) % NR;
          phase = 1;
        end
      end else if (phase == 1) begin
        checks++;
        if (req_ready !== '0 || resp_valid !== '0) begin
          errors++;
          $display("FAIL rand_exec@%0d: ready=%b valid=%b want 0000/0000", c, req_ready, resp_valid);
        end
        phase = 2;
      end else begin
        er = NR'(1) << eid;
        checks++;
        if (resp_valid !== er || resp_data !== edata || req_ready !== '0) begin
          errors++;
          $display("FAIL rand_resp@%0d: valid=%b data=%h ready=%b want %b/%h/0000", c, resp_valid, resp_data, req_ready, er, edata);
        end
        if (resp_ready[eid]) phase = 0;
      end
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_alternate();
    test_backpressure();
    test_async_reset();
    test_lone();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
